// File: rtl/frv_gpr_pkg.sv
// rtl/frv_gpr_pkg.sv - shared GPR widths, x0 constant and write legalisation
package frv_gpr_pkg;

    localparam int GPR_AW  = 5;
    localparam int GPR_DW  = 32;
    localparam int GPR_NUM = 32;

    localparam logic [GPR_AW-1:0] GPR_X0 = '0;

    typedef struct packed {
        logic wen;
        logic wide;
    } gpr_legal_t;

    // A wide write needs an even base; odd bases degrade to narrow.
    // A narrow write to x0 is dropped, but a wide one still writes x1.
    function automatic gpr_legal_t gpr_legalise(input logic [GPR_AW-1:0] addr,
                                                input logic              wide);
        gpr_legal_t r;
        r.wide = wide && !addr[0];
        r.wen  = r.wide || (addr != GPR_X0);
        return r;
    endfunction

endpackage

// File: rtl/frv_gpr_scoreboard.sv
// rtl/frv_gpr_scoreboard.sv - pending long-latency write vector with three read ports
module frv_gpr_scoreboard
    import frv_gpr_pkg::*;
(
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              set_valid,
    input  logic [GPR_AW-1:0] set_addr,
    input  logic              set_wide,
    input  logic              clr_valid,
    input  logic [GPR_AW-1:0] clr_addr,
    input  logic              clr_wide,
    input  logic [GPR_AW-1:0] rs1_addr,
    input  logic [GPR_AW-1:0] rs2_addr,
    input  logic [GPR_AW-1:0] rs3_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rs3_busy
);

    logic [GPR_NUM-1:0] busy;
    logic [GPR_NUM-1:0] set_mask;
    logic [GPR_NUM-1:0] clr_mask;
    gpr_legal_t         clr_legal;

    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        clr_legal = gpr_legalise(clr_addr, clr_wide);
        if (set_valid) begin
            set_mask[set_addr] = 1'b1;
            if (set_wide && !set_addr[0]) begin
                set_mask[set_addr | GPR_AW'(1)] = 1'b1;
            end
        end
        set_mask[0] = 1'b0;
        if (clr_valid && clr_legal.wen) begin
            clr_mask[clr_addr] = 1'b1;
            if (clr_legal.wide) begin
                clr_mask[clr_addr | GPR_AW'(1)] = 1'b1;
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit busy.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign rs3_busy = busy[rs3_addr];

endmodule

// File: rtl/frv_gpr_wb_arbiter.sv
// rtl/frv_gpr_wb_arbiter.sv - GPR write port arbiter with pending scoreboard; FRV_GPR_ARB_FWD_EN adds forwarding
module frv_gpr_wb_arbiter
    import frv_gpr_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [GPR_AW-1:0] p_addr,
    input  logic              p_wide,
    input  logic [GPR_DW-1:0] p_wdata,
    input  logic [GPR_DW-1:0] p_wdata_hi,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [GPR_AW-1:0] s_addr,
    input  logic              s_wide,
    input  logic [GPR_DW-1:0] s_wdata,
    input  logic [GPR_DW-1:0] s_wdata_hi,
    input  logic              iss_valid,
    input  logic [GPR_AW-1:0] iss_addr,
    input  logic              iss_wide,
    input  logic [GPR_AW-1:0] rs1_addr,
    input  logic [GPR_AW-1:0] rs2_addr,
    input  logic [GPR_AW-1:0] rs3_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rs3_busy,
`ifdef FRV_GPR_ARB_FWD_EN
    output logic              rs1_fwd,
    output logic              rs2_fwd,
    output logic              rs3_fwd,
    output logic [GPR_DW-1:0] rs1_fwd_data,
    output logic [GPR_DW-1:0] rs2_fwd_data,
    output logic [GPR_DW-1:0] rs3_fwd_data,
`endif
    output logic              rd_wen,
    output logic              rd_wide,
    output logic [GPR_AW-1:0] rd_addr,
    output logic [GPR_DW-1:0] rd_wdata,
    output logic [GPR_DW-1:0] rd_wdata_hi
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt;
    logic              s_force;
    logic              s_grant;
    logic              p_grant;
    logic [GPR_AW-1:0] sel_addr;
    logic              sel_wide;
    logic [GPR_DW-1:0] sel_lo;
    logic [GPR_DW-1:0] sel_hi;
    gpr_legal_t        sel_legal;

    assign s_force = s_valid && (starve_cnt == STARVE_MAX);
    assign s_grant = s_valid && (s_force || !p_valid);
    assign p_grant = p_valid && !s_force;
    assign p_ready = p_grant;
    assign s_ready = s_grant;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt <= '0;
        end else if (!s_valid || s_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_comb begin
        sel_addr  = s_grant ? s_addr     : p_addr;
        sel_wide  = s_grant ? s_wide     : p_wide;
        sel_lo    = s_grant ? s_wdata    : p_wdata;
        sel_hi    = s_grant ? s_wdata_hi : p_wdata_hi;
        sel_legal = gpr_legalise(sel_addr, sel_wide);
    end

    // rd_addr/rd_wdata hold their last value in idle cycles; only rd_wen/rd_wide drop.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_wen      <= 1'b0;
            rd_wide     <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            rd_wdata_hi <= '0;
        end else if (p_grant || s_grant) begin
            rd_wen      <= sel_legal.wen;
            rd_wide     <= sel_legal.wide;
            rd_addr     <= sel_addr;
            rd_wdata    <= sel_lo;
            rd_wdata_hi <= sel_legal.wide ? sel_hi : '0;
        end else begin
            rd_wen  <= 1'b0;
            rd_wide <= 1'b0;
        end
    end

    frv_gpr_scoreboard u_scoreboard (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .set_valid (iss_valid),
        .set_addr  (iss_addr),
        .set_wide  (iss_wide),
        .clr_valid (s_grant),
        .clr_addr  (s_addr),
        .clr_wide  (s_wide),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs3_addr  (rs3_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rs3_busy  (rs3_busy)
    );

`ifdef FRV_GPR_ARB_FWD_EN
    logic [2:0][GPR_AW-1:0] fwd_rs;
    logic [2:0]             fwd_hit;
    logic [2:0][GPR_DW-1:0] fwd_data;

    assign fwd_rs = {rs3_addr, rs2_addr, rs1_addr};

    // Covers the cycle where rd_* is on the regfile port but not yet readable.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (rd_wen && (fwd_rs[i] != GPR_X0)) begin
                if (fwd_rs[i] == rd_addr) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = rd_wdata;
                end else if (rd_wide && (fwd_rs[i] == (rd_addr | GPR_AW'(1)))) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = rd_wdata_hi;
                end
            end
        end
    end

    assign rs1_fwd      = fwd_hit[0];
    assign rs2_fwd      = fwd_hit[1];
    assign rs3_fwd      = fwd_hit[2];
    assign rs1_fwd_data = fwd_data[0];
    assign rs2_fwd_data = fwd_data[1];
    assign rs3_fwd_data = fwd_data[2];
`endif

endmodule

// File: tb/tb_frv_gpr_wb_arbiter.sv
// tb/tb_frv_gpr_wb_arbiter.sv - directed self-checking bench for frv_gpr_wb_arbiter
module tb_frv_gpr_wb_arbiter;

    logic        g_clk;
    logic        g_resetn;
    logic        p_valid, p_ready, p_wide;
    logic [4:0]  p_addr;
    logic [31:0] p_wdata, p_wdata_hi;
    logic        s_valid, s_ready, s_wide;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata, s_wdata_hi;
    logic        iss_valid, iss_wide;
    logic [4:0]  iss_addr;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
    logic        rs1_busy, rs2_busy, rs3_busy;
    logic        rd_wen, rd_wide;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;
`ifdef FRV_GPR_ARB_FWD_EN
    logic        rs1_fwd, rs2_fwd, rs3_fwd;
    logic [31:0] rs1_fwd_data, rs2_fwd_data, rs3_fwd_data;
`endif

    int total = 0;
    int bad   = 0;
    logic sg;

    frv_gpr_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .g_clk        (g_clk),
        .g_resetn     (g_resetn),
        .p_valid      (p_valid),
        .p_ready      (p_ready),
        .p_addr       (p_addr),
        .p_wide       (p_wide),
        .p_wdata      (p_wdata),
        .p_wdata_hi   (p_wdata_hi),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_addr       (s_addr),
        .s_wide       (s_wide),
        .s_wdata      (s_wdata),
        .s_wdata_hi   (s_wdata_hi),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .iss_wide     (iss_wide),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs3_addr     (rs3_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs3_busy     (rs3_busy),
`ifdef FRV_GPR_ARB_FWD_EN
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .rs3_fwd      (rs3_fwd),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
        .rs3_fwd_data (rs3_fwd_data),
`endif
        .rd_wen       (rd_wen),
        .rd_wide      (rd_wide),
        .rd_addr      (rd_addr),
        .rd_wdata     (rd_wdata),
        .rd_wdata_hi  (rd_wdata_hi)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn = 1'b0;
        p_valid = 0; p_wide = 0; p_addr = 0; p_wdata = 0; p_wdata_hi = 0;
        s_valid = 0; s_wide = 0; s_addr = 0; s_wdata = 0; s_wdata_hi = 0;
        iss_valid = 0; iss_wide = 0; iss_addr = 0;
        rs1_addr = 0; rs2_addr = 0; rs3_addr = 0;
        tick; tick;
        chk("rst_wen",  rd_wen, 0);
        chk("rst_wide", rd_wide, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_lo",   rd_wdata, 0);
        chk("rst_hi",   rd_wdata_hi, 0);
        chk("rst_busy", {rs1_busy, rs2_busy, rs3_busy}, 0);
        g_resetn = 1'b1;
        tick;

        // continuous contention: 4 primary grants then 1 secondary
        p_valid = 1; p_addr = 5'd2; s_valid = 1; s_addr = 5'd4;
        for (int i = 0; i < 10; i++) begin
            p_wdata = 32'h100 + i;
            s_wdata = 32'h200 + i;
            #1;
            sg = (i % 5 == 4);
            chk("st_p_ready", p_ready, !sg);
            chk("st_s_ready", s_ready, sg);
            tick;
            chk("st_wen",  rd_wen, 1);
            chk("st_addr", rd_addr, sg ? 5'd4 : 5'd2);
            chk("st_data", rd_wdata, sg ? 32'h200 + i : 32'h100 + i);
        end
        p_valid = 0; s_valid = 0;
        tick;
        chk("idle_wen", rd_wen, 0);

        // wide issue to 6 marks 6 and 7; secondary wide write clears both
        iss_valid = 1; iss_addr = 5'd6; iss_wide = 1;
        rs1_addr = 5'd7; rs2_addr = 5'd6; rs3_addr = 5'd8;
        tick;
        iss_valid = 0;
        chk("sb_busy7", rs1_busy, 1);
        chk("sb_busy6", rs2_busy, 1);
        chk("sb_busy8", rs3_busy, 0);
        s_valid = 1; s_addr = 5'd6; s_wide = 1; s_wdata = 32'h11; s_wdata_hi = 32'h22;
        #1;
        chk("sb_s_ready", s_ready, 1);
        tick;
        s_valid = 0;
        chk("sb_wen",  rd_wen, 1);
        chk("sb_wide", rd_wide, 1);
        chk("sb_addr", rd_addr, 6);
        chk("sb_lo",   rd_wdata, 32'h11);
        chk("sb_hi",   rd_wdata_hi, 32'h22);
        chk("sb_clr7", rs1_busy, 0);
        chk("sb_clr6", rs2_busy, 0);

        // same-cycle set and clear: set wins
        iss_valid = 1; iss_addr = 5'd9; iss_wide = 0;
        s_valid = 1; s_addr = 5'd9; s_wide = 0; s_wdata = 32'h33;
        rs3_addr = 5'd9;
        tick;
        iss_valid = 0; s_valid = 0;
        chk("sc_busy9", rs3_busy, 1);
        chk("sc_addr",  rd_addr, 9);
        s_valid = 1;
        tick;
        s_valid = 0;
        chk("sc_clr9", rs3_busy, 0);

        // wide issue on odd address marks only that register
        iss_valid = 1; iss_addr = 5'd11; iss_wide = 1;
        rs1_addr = 5'd11; rs2_addr = 5'd12;
        tick;
        iss_valid = 0;
        chk("odd_busy11", rs1_busy, 1);
        chk("odd_busy12", rs2_busy, 0);
        s_valid = 1; s_addr = 5'd11; s_wide = 1; s_wdata_hi = 32'h77;
        tick;
        s_valid = 0;
        chk("odd_clr11", rs1_busy, 0);
        chk("odd_wide",  rd_wide, 0);
        chk("odd_hi",    rd_wdata_hi, 0);

        // address legalisation on the primary
        p_valid = 1; p_wide = 1; p_addr = 5'd5; p_wdata = 32'h55; p_wdata_hi = 32'hAAAA;
        tick;
        chk("lg_wen5",  rd_wen, 1);
        chk("lg_wide5", rd_wide, 0);
        chk("lg_addr5", rd_addr, 5);
        chk("lg_hi5",   rd_wdata_hi, 0);
        p_wide = 0; p_addr = 5'd0;
        #1;
        chk("lg_x0_ready", p_ready, 1);
        tick;
        chk("lg_x0_wen", rd_wen, 0);
        p_wide = 1; p_wdata_hi = 32'h5555;
        tick;
        chk("lg_x0w_wen",  rd_wen, 1);
        chk("lg_x0w_wide", rd_wide, 1);
        chk("lg_x0w_hi",   rd_wdata_hi, 32'h5555);
        p_valid = 0; p_wide = 0;
        tick;

`ifdef FRV_GPR_ARB_FWD_EN
        p_valid = 1; p_addr = 5'd3; p_wdata = 32'hDEADBEEF; rs2_addr = 5'd3; rs3_addr = 5'd1;
        tick;
        chk("fw_rs2",      rs2_fwd, 1);
        chk("fw_rs2_data", rs2_fwd_data, 32'hDEADBEEF);
        chk("fw_rs3_miss", rs3_fwd, 0);
        p_addr = 5'd0; p_wide = 1; p_wdata = 32'h1; p_wdata_hi = 32'hCAFE; rs2_addr = 5'd0;
        tick;
        chk("fw_rs2_x0",   rs2_fwd, 0);
        chk("fw_rs2_x0d",  rs2_fwd_data, 0);
        chk("fw_rs3_hi",   rs3_fwd, 1);
        chk("fw_rs3_hid",  rs3_fwd_data, 32'hCAFE);
        p_valid = 0; p_wide = 0;
        tick;
        chk("fw_idle", rs3_fwd, 0);
`endif

        // asynchronous reset mid-cycle
        iss_valid = 1; iss_addr = 5'd12; iss_wide = 0;
        p_valid = 1; p_addr = 5'd12; p_wdata = 32'h99; rs1_addr = 5'd12;
        tick;
        iss_valid = 0; p_valid = 0;
        chk("ar_pre_wen",  rd_wen, 1);
        chk("ar_pre_busy", rs1_busy, 1);
        g_resetn = 1'b0;
        #1;
        chk("ar_wen",  rd_wen, 0);
        chk("ar_busy", rs1_busy, 0);
        chk("ar_addr", rd_addr, 0);
        chk("ar_lo",   rd_wdata, 0);
        #2;
        g_resetn = 1'b1;
        tick;
        chk("ar_post_wen", rd_wen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frv_gpr_wb_arbiter.md
Name: frv_gpr_wb_arbiter

Overview:
- Shares the single GPR write port (lo/hi, wide-capable) between two requesters:
  - Primary: pipeline writeback.
  - Secondary: long-latency units (div, misaligned load).
- Keeps a 32-entry pending-write scoreboard so decode can stall on registers with an outstanding long-latency result.
- Sits between writeback/long-latency units and the GPR file; its registered rd_* outputs drive the register file write port directly.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the secondary may wait with valid high before it is forced ahead of the primary; legal range 1..15.

Ports:
- g_clk  in  1  core clock
- g_resetn  in  1  asynchronous active-low reset
- p_valid  in  1  primary write request
- p_ready  out  1  primary request accepted this cycle
- p_addr  in  5  primary destination
- p_wide  in  1  primary 64-bit write
- p_wdata  in  32  primary data [31:0]
- p_wdata_hi  in  32  primary data [63:32]
- s_valid  in  1  secondary write request
- s_ready  out  1  secondary request accepted this cycle
- s_addr  in  5  secondary destination
- s_wide  in  1  secondary 64-bit write
- s_wdata  in  32  secondary data [31:0]
- s_wdata_hi  in  32  secondary data [63:32]
- iss_valid  in  1  long-latency op issued; mark destination pending
- iss_addr  in  5  issued op destination
- iss_wide  in  1  issued op is wide
- rs1_addr / rs2_addr / rs3_addr  in  5 each  decode source addresses
- rs1_busy / rs2_busy / rs3_busy  out  1 each  source has a pending long-latency write
- rd_wen  out  1  register-file write enable
- rd_wide  out  1  register-file wide write
- rd_addr  out  5  register-file destination
- rd_wdata  out  32  register-file data lo
- rd_wdata_hi  out  32  register-file data hi

Behaviour:
- Reset (async, g_resetn low):
  - rd_wen=0, rd_wide=0, rd_addr=0, rd_wdata=0, rd_wdata_hi=0.
  - Scoreboard all clear; starvation counter 0.
  - A transaction in flight is discarded; its requester re-presents after reset.
- Grant (combinational, at most one per cycle):
  - Default: primary wins; s_ready = s_valid && !p_valid.
  - Starvation counter increments each cycle s_valid && !s_ready, saturating at STARVE_LIMIT; clears on secondary accept or when s_valid is low.
  - When counter == STARVE_LIMIT: secondary wins, p_ready=0 for that cycle, counter clears.
  - p_ready/s_ready are never both 1.
- Write stage (registered, 1-cycle latency): an accepted request appears on rd_* on the next cycle for exactly one cycle; rd_wen=0 in idle cycles.
- Address legalisation:
  - Wide with odd addr is issued narrow (rd_wide=0, hi dropped).
  - Narrow write to x0: handshake completes, rd_wen=0.
  - Wide to x0: rd_wen=1, rd_wide=1 (regfile ignores even-0, writes x1 with hi).
- Scoreboard:
  - iss_valid sets bit iss_addr.
  - iss_valid with iss_wide and even iss_addr also sets bit iss_addr|1.
  - An accepted secondary write clears the same bit(s), using its own wide/addr legalisation.
  - Simultaneous set and clear of the same bit: set wins.
  - Bit 0 is never set.
  - rsN_busy = scoreboard[rsN_addr], read from the registered state.
- Primary writes never touch the scoreboard.

Optional Feature:
- Macro: FRV_GPR_ARB_FWD_EN.
- When defined, adds outputs rs1_fwd / rs2_fwd / rs3_fwd (1 each) and rs1_fwd_data / rs2_fwd_data / rs3_fwd_data (32 each).
  - rsN_fwd=1 when rd_wen is high and the rd_* write covers rsN_addr (rsN_addr != 0): lo word on rd_addr, hi word on rd_addr|1 when rd_wide.
  - rsN_fwd_data carries the matching word; otherwise 0.
  - This covers the cycle before the register file holds the value.
- When undefined, the ports are absent and decode reads the register file only.

Decomposition:
- Shared package frv_gpr_pkg: GPR address width (5), data width (32), register count (32), x0 constant, and a legalise-address function (returns wen, wide).
- One natural sub-module: frv_gpr_scoreboard, holding the busy vector, set/clear logic and three read ports.

Test Plan:
- p_valid and s_valid high continuously, STARVE_LIMIT=4: grants follow the pattern 4 primary, 1 secondary, repeating; each accepted write appears on rd_* exactly one cycle after acceptance.
- iss_valid addr=6 wide=1, then rs1_addr=7: rs1_busy=1 from the next cycle. Secondary write addr=6 wide=1 lo=0x11 hi=0x22 accepted: rd_wen=1, rd_wide=1, rd_addr=6, and rs1_busy=0 the following cycle.
- Same cycle: iss_valid addr=9 and secondary write to 9 accepted -> bit 9 stays busy.
- p_wide=1 p_addr=5: rd_wide=0, rd_addr=5. p_addr=0 narrow: p_ready=1, rd_wen=0.
- g_resetn pulsed low with rd_wen=1 and busy bits set: rd_wen=0 and all busy clear immediately, without waiting for a clock edge.
- With FRV_GPR_ARB_FWD_EN: write to x3=0xDEADBEEF with rs2_addr=3 -> rs2_fwd=1 and rs2_fwd_data=0xDEADBEEF in the rd_wen cycle. rs2_addr=0 -> rs2_fwd=0.
